// File: rtl/mesh_pkg.sv
// -----------------------------------------------------------------------------
// mesh_pkg
// Shared definitions for the 5-port mesh router input stage.
//   - Output port index constants (North..Local) and the one-hot port type.
//   - Flit field offsets: dest X at bit 0, dest Y directly above it, then the
//     payload.
//   - Default destination coordinate width.
// -----------------------------------------------------------------------------
package mesh_pkg;

  localparam int PORT_NORTH = 0;
  localparam int PORT_EAST  = 1;
  localparam int PORT_SOUTH = 2;
  localparam int PORT_WEST  = 3;
  localparam int PORT_LOCAL = 4;
  localparam int NUM_PORTS  = 5;

  localparam int DEFAULT_COORD_WIDTH = 3;

  // One-hot output port request {Local,West,South,East,North}
  typedef logic [NUM_PORTS-1:0] port_onehot_t;

  localparam int DEST_X_LSB = 0;

  function automatic int dest_y_lsb(input int coord_width);
    return coord_width;
  endfunction

  function automatic int payload_lsb(input int coord_width);
    return 2 * coord_width;
  endfunction

endpackage : mesh_pkg

// File: rtl/mesh_input_unit_xy_route_compute.sv
// -----------------------------------------------------------------------------
// xy_route_compute
// Combinational XY dimension-order route computation. X is resolved first,
// then Y; a flit whose destination matches this router goes to Local.
// Ports:
//   dest_x, dest_y : destination coordinates of the head flit
//   port_req       : one-hot output port {Local,West,South,East,North}
// Comparisons are unsigned at COORD_WIDTH.
// -----------------------------------------------------------------------------
module xy_route_compute
  import mesh_pkg::*;
#(
  parameter int COORD_WIDTH = DEFAULT_COORD_WIDTH,
  parameter int LOCAL_X     = 0,
  parameter int LOCAL_Y     = 0
) (
  input  logic [COORD_WIDTH-1:0] dest_x,
  input  logic [COORD_WIDTH-1:0] dest_y,
  output port_onehot_t           port_req
);

  localparam logic [COORD_WIDTH-1:0] LX = COORD_WIDTH'(LOCAL_X);
  localparam logic [COORD_WIDTH-1:0] LY = COORD_WIDTH'(LOCAL_Y);

  always_comb begin
    port_req = '0;
    if (dest_x > LX) begin
      port_req[PORT_EAST] = 1'b1;
    end else if (dest_x < LX) begin
      port_req[PORT_WEST] = 1'b1;
    end else if (dest_y > LY) begin
      port_req[PORT_NORTH] = 1'b1;
    end else if (dest_y < LY) begin
      port_req[PORT_SOUTH] = 1'b1;
    end else begin
      port_req[PORT_LOCAL] = 1'b1;
    end
  end

endmodule : xy_route_compute

// File: rtl/mesh_input_unit.sv
// -----------------------------------------------------------------------------
// mesh_input_unit
// Per-port input stage of the 5-port mesh router. Buffers flits in a circular
// FIFO, computes the XY-routed output port of the head flit and presents it
// to the switch allocator as a one-hot request.
// Ports:
//   clk, reset (async, active-low)
//   dataIn / writeRequest : flit and write strobe from upstream
//   readRequest           : pop strobe from the allocator
//   dataOut               : registered popped flit to the crossbar (1 cycle
//                           after readRequest)
//   outputPortRequest     : one-hot {Local,West,South,East,North}, 0 if empty
//   holdPort              : back-pressure, high when count >= DEPTH-1
//   overflowCount         : (MESH_INPUT_OVERFLOW_CHECK_EN only) saturating
//                           count of dropped writes
// Optional feature macro: MESH_INPUT_OVERFLOW_CHECK_EN
// -----------------------------------------------------------------------------
module mesh_input_unit
  import mesh_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int COORD_WIDTH = DEFAULT_COORD_WIDTH,
  parameter int LOCAL_X     = 0,
  parameter int LOCAL_Y     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  writeRequest,
  input  logic                  readRequest,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic [4:0]            outputPortRequest,
`ifdef MESH_INPUT_OVERFLOW_CHECK_EN
  output logic [15:0]           overflowCount,
`endif
  output logic                  holdPort
);

  localparam int PTR_W      = $clog2(DEPTH);
  localparam int CNT_W      = $clog2(DEPTH) + 1;
  localparam int DEST_Y_LSB = dest_y_lsb(COORD_WIDTH);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_HOLD = CNT_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  logic                  wr_en;
  logic                  rd_en;
  port_onehot_t          route_port;

  // Full/empty decisions use the pre-edge count: a write at full is dropped
  // even if a read frees a slot in the same cycle, and a read at empty is
  // ignored even if a write lands in the same cycle (no bypass).
  assign wr_en = writeRequest && (count_q != CNT_FULL);
  assign rd_en = readRequest  && (count_q != '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      data_out_d = mem_q[rd_ptr_q];
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= dataIn;
    end
  end

  xy_route_compute #(
    .COORD_WIDTH (COORD_WIDTH),
    .LOCAL_X     (LOCAL_X),
    .LOCAL_Y     (LOCAL_Y)
  ) u_route (
    .dest_x   (mem_q[rd_ptr_q][DEST_X_LSB +: COORD_WIDTH]),
    .dest_y   (mem_q[rd_ptr_q][DEST_Y_LSB +: COORD_WIDTH]),
    .port_req (route_port)
  );

  assign dataOut           = data_out_q;
  assign outputPortRequest = (count_q == '0) ? '0 : route_port;
  // One slot of margin absorbs the write already in flight from upstream.
  assign holdPort          = (count_q >= CNT_HOLD);

`ifdef MESH_INPUT_OVERFLOW_CHECK_EN
  logic        wr_drop;
  logic [15:0] overflow_count_q, overflow_count_d;

  assign wr_drop = writeRequest && (count_q == CNT_FULL);

  always_comb begin
    overflow_count_d = overflow_count_q;
    if (wr_drop && (overflow_count_q != 16'hFFFF)) begin
      overflow_count_d = overflow_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_count_q <= '0;
    end else begin
      overflow_count_q <= overflow_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!wr_drop) else $warning("mesh_input_unit: write dropped, buffer full");
    end
  end

  assign overflowCount = overflow_count_q;
`endif

endmodule : mesh_input_unit

// File: tb/tb_mesh_input_unit.sv
module tb_mesh_input_unit;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int CW    = 3;
  localparam int LX    = 1;
  localparam int LY    = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] dataIn = '0;
  logic          writeRequest = 1'b0;
  logic          readRequest = 1'b0;
  logic [DW-1:0] dataOut;
  logic [4:0]    outputPortRequest;
  logic          holdPort;
`ifdef MESH_INPUT_OVERFLOW_CHECK_EN
  logic [15:0]   overflowCount;
  int            exp_ovf = 0;
`endif

  mesh_input_unit #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .COORD_WIDTH(CW), .LOCAL_X(LX), .LOCAL_Y(LY)
  ) dut (
    .clk(clk), .reset(reset), .dataIn(dataIn), .writeRequest(writeRequest),
    .readRequest(readRequest), .dataOut(dataOut),
    .outputPortRequest(outputPortRequest),
`ifdef MESH_INPUT_OVERFLOW_CHECK_EN
    .overflowCount(overflowCount),
`endif
    .holdPort(holdPort)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: flits accepted into the buffer, in order
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] exp_dout = '0;

  typedef struct {
    logic [CW-1:0] dx;
    logic [CW-1:0] dy;
    logic [4:0]    exp_port;
  } route_vec_t;

  route_vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_flit(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                            input int payload);
    logic [DW-1:0] f;
    f = '0;
    f[CW-1:0]    = x;
    f[2*CW-1:CW] = y;
    f[DW-1:2*CW] = payload[DW-2*CW-1:0];
    return f;
  endfunction

  function automatic logic [4:0] ref_route(input logic [DW-1:0] f);
    logic [CW-1:0] x, y;
    x = f[CW-1:0];
    y = f[2*CW-1:CW];
    if (x > CW'(LX))      return 5'b00010;
    else if (x < CW'(LX)) return 5'b01000;
    else if (y > CW'(LY)) return 5'b00001;
    else if (y < CW'(LY)) return 5'b00100;
    else                  return 5'b10000;
  endfunction

  // One clock of stimulus; model updated with the pre-edge occupancy, then
  // all outputs compared #1 after the edge.
  task automatic step(input logic wr, input logic rd, input logic [DW-1:0] din);
    int pre;
    writeRequest = wr;
    readRequest  = rd;
    dataIn       = din;
    @(posedge clk);
    pre = sb_q.size();
    if (rd && pre > 0) exp_dout = sb_q.pop_front();
    if (wr && pre < DEPTH) sb_q.push_back(din);
`ifdef MESH_INPUT_OVERFLOW_CHECK_EN
    if (wr && pre == DEPTH && exp_ovf < 65535) exp_ovf++;
`endif
    #1;
    writeRequest = 1'b0;
    readRequest  = 1'b0;
    check("dataOut", dataOut, exp_dout);
    check("holdPort", {31'b0, holdPort}, {31'b0, sb_q.size() >= DEPTH - 1});
    check("outputPortRequest", {27'b0, outputPortRequest},
          {27'b0, (sb_q.size() == 0) ? 5'b0 : ref_route(sb_q[0])});
`ifdef MESH_INPUT_OVERFLOW_CHECK_EN
    check("overflowCount", {16'b0, overflowCount}, exp_ovf);
`endif
    $display("t=%0t wr=%0b rd=%0b din=%0h -> dout=%0h req=%05b hold=%0b occ=%0d",
             $time, wr, rd, din, dataOut, outputPortRequest, holdPort, sb_q.size());
  endtask

  task automatic drain();
    while (sb_q.size() > 0) step(1'b0, 1'b1, '0);
  endtask

  initial begin
    tbl[0] = '{dx: 3'd3, dy: 3'd1, exp_port: 5'b00010};
    tbl[1] = '{dx: 3'd0, dy: 3'd2, exp_port: 5'b01000};
    tbl[2] = '{dx: 3'd1, dy: 3'd3, exp_port: 5'b00001};
    tbl[3] = '{dx: 3'd1, dy: 3'd0, exp_port: 5'b00100};
    tbl[4] = '{dx: 3'd1, dy: 3'd1, exp_port: 5'b10000};

    // Reset and idle
    reset = 1'b0;
    #12;
    check("reset dataOut", dataOut, 0);
    check("reset outputPortRequest", {27'b0, outputPortRequest}, 0);
    check("reset holdPort", {31'b0, holdPort}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 1'b1, '0);   // read while empty is ignored
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b0, mk_flit(3'd1, 3'd1, 'h55));   // occupancy must be exactly 1
    check("single write no hold", {31'b0, holdPort}, 0);
    drain();

    // Routing table: 4 fill the buffer, the 5th is dropped
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, mk_flit(tbl[i].dx, tbl[i].dy, 16 + i));
    check("route head 0", {27'b0, outputPortRequest}, {27'b0, tbl[0].exp_port});
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b0, mk_flit(tbl[4].dx, tbl[4].dy, 20));
    for (int i = 1; i < 5; i++) begin
      check($sformatf("route head %0d", i), {27'b0, outputPortRequest}, {27'b0, tbl[i].exp_port});
      step(1'b0, 1'b1, '0);
    end

    // holdPort threshold and drop at full
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, mk_flit(3'd2, 3'd0, 32 + i));
    check("hold at 3", {31'b0, holdPort}, 1);
    step(1'b1, 1'b0, mk_flit(3'd0, 3'd0, 35));
    step(1'b1, 1'b0, mk_flit(3'd1, 3'd2, 36));   // dropped
    drain();
    check("hold after drain", {31'b0, holdPort}, 0);

    // Pointer wrap: stream payloads 0..9 alternating read/write around count 2
    step(1'b1, 1'b0, mk_flit(3'd1, 3'd2, 0));
    step(1'b1, 1'b0, mk_flit(3'd1, 3'd2, 1));
    for (int k = 2; k < 10; k++) begin
      step(1'b0, 1'b1, '0);
      check("wrap order", {6'b0, dataOut[DW-1:2*CW]}, k - 2);
      step(1'b1, 1'b0, mk_flit(3'd0, 3'd1, k));
    end
    for (int k = 8; k < 10; k++) begin
      step(1'b0, 1'b1, '0);
      check("wrap order tail", {6'b0, dataOut[DW-1:2*CW]}, k);
    end

    // Simultaneous read and write at full, then at count 2
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, mk_flit(3'd4, 3'd4, 48 + i));
    step(1'b1, 1'b1, mk_flit(3'd0, 3'd0, 60));   // read proceeds, write dropped
    check("full rw payload", {6'b0, dataOut[DW-1:2*CW]}, 48);
    step(1'b0, 1'b1, '0);                        // occupancy now 2
    step(1'b1, 1'b1, mk_flit(3'd0, 3'd0, 61));   // both take effect
    check("mid rw hold", {31'b0, holdPort}, 0);
    drain();
    check("stored rw payload", {6'b0, dataOut[DW-1:2*CW]}, 61);

    // Asynchronous reset mid-stream at count 3
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, mk_flit(3'd5, 3'd1, 70 + i));
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b0, mk_flit(3'd5, 3'd1, 73));
    #2;
    reset = 1'b0;
    #1;
    check("async rst dataOut", dataOut, 0);
    check("async rst req", {27'b0, outputPortRequest}, 0);
    check("async rst hold", {31'b0, holdPort}, 0);
    sb_q.delete();
    exp_dout = '0;
`ifdef MESH_INPUT_OVERFLOW_CHECK_EN
    exp_ovf = 0;
`endif
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b0, mk_flit(3'd1, 3'd0, 80));
    check("post reset route", {27'b0, outputPortRequest}, 5'b00100);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
